alu_op_sequencer: RTL and testbench

Initiator side of the ALU interface. The ALU only answers; this block drives it. It accepts operation requests over a valid/ready handshake and drives A, B and FunSel into the alu block. It waits for the clocked ZCNO flags, captures OutALU and ZCNO, and can chain repeated operations by feeding OutALU back into A. The block sits between the control unit / bench driver and the alu.

---
 rtl/alu_op_sequencer_if.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the request channel, the response channel and the ALU operand /
// result bus seen by alu_op_sequencer.
//   master : the sequencer itself (drives A/B/FunSel, ReqReady, Rsp*, Busy)
//   slave  : its environment (request source, response sink and the alu)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             ReqValid;
    logic             ReqReady;
    logic [3:0]       ReqFunSel;
    logic [WIDTH-1:0] ReqA;
    logic [WIDTH-1:0] ReqB;
    logic [CNT_W-1:0] ReqRepeat;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       FunSel;
    logic [WIDTH-1:0] OutALU;
    logic [3:0]       ZCNO;
    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspData;
    logic [3:0]       RspZCNO;
    logic             Busy;

    modport master (
        input  ReqValid, ReqFunSel, ReqA, ReqB, ReqRepeat,
        input  OutALU, ZCNO, RspReady,
        output ReqReady, A, B, FunSel, RspValid, RspData, RspZCNO, Busy
    );

    modport slave (
        output ReqValid, ReqFunSel, ReqA, ReqB, ReqRepeat,
        output OutALU, ZCNO, RspReady,
        input  ReqReady, A, B, FunSel, RspValid, RspData, RspZCNO, Busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Drives the alu: accepts a request, presents A/B/FunSel, waits for the
// clocked ZCNO flags, captures OutALU/ZCNO and optionally repeats the
// operation with OutALU fed back into A.
// Ports:
//   CLK    : system clock, rising edge
//   Reset  : synchronous, active-low reset
//   bus    : alu_op_sequencer_if.master (request, response, alu operand bus)
//
// state  | meaning
// IDLE   | ReqReady=1, waiting for a request
// EXEC   | operands stable, alu updates ZCNO on the closing edge
// SAMPLE | OutALU/ZCNO valid, capture; loop back to EXEC while cnt!=0
// RESP   | RspValid=1, result held until RspReady
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    alu_op_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_a,         w_a_nxt;
    logic [WIDTH-1:0] r_b,         w_b_nxt;
    logic [3:0]       r_funsel,    w_funsel_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDTH-1:0] r_rsp_data,  w_rsp_data_nxt;
    logic [3:0]       r_rsp_zcno,  w_rsp_zcno_nxt;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_funsel    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zcno  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_funsel    <= w_funsel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_zcno  <= w_rsp_zcno_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_funsel_nxt    = r_funsel;
        w_cnt_nxt       = r_cnt;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_zcno_nxt  = r_rsp_zcno;
        case (r_state)
            IDLE: begin
                if (bus.ReqValid) begin
                    w_a_nxt      = bus.ReqA;
                    w_b_nxt      = bus.ReqB;
                    w_funsel_nxt = bus.ReqFunSel;
                    w_cnt_nxt    = bus.ReqRepeat;
                    w_state_nxt  = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                w_rsp_data_nxt = bus.OutALU;
                w_rsp_zcno_nxt = bus.ZCNO;
                if (r_cnt != '0) begin
                    // Chained operation: result becomes the next A operand.
                    w_a_nxt     = bus.OutALU;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_state_nxt = EXEC;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                if (bus.RspReady) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ReqReady = (r_state == IDLE);
    assign bus.Busy     = (r_state != IDLE);
    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.FunSel   = r_funsel;
    assign bus.RspValid = r_rsp_valid;
    assign bus.RspData  = r_rsp_data;
    assign bus.RspZCNO  = r_rsp_zcno;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with a small behavioural alu:
//   FunSel 4'h4 : A+B, 4'hF : rotate A left by one, others : pass A.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic CLK;
    logic Reset;

    int checks;
    int failures;

    alu_op_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

    alu_op_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural alu: returns {OutALU, Z, C, N, O}
    function automatic logic [11:0] alu_f(input logic [3:0] fs,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] sum;
        logic [7:0] res;
        logic       c;
        logic       o;
        sum = 9'd0;
        c   = 1'b0;
        o   = 1'b0;
        case (fs)
            4'h4: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[7:0];
                c   = sum[8];
                o   = (a[7] == b[7]) && (res[7] != a[7]);
            end
            4'hF: begin
                res = {a[6:0], a[7]};
                c   = a[7];
            end
            default: res = a;
        endcase
        return {res, (res == 8'h00), c, res[7], o};
    endfunction

    logic [11:0] w_alu;
    assign w_alu = alu_f(bus.FunSel, bus.A, bus.B);
    assign bus.OutALU = w_alu[11:4];

    initial bus.ZCNO = 4'b0000;
    always @(posedge CLK) bus.ZCNO <= w_alu[3:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Presents a request at a negedge and returns after the accepting edge
    // and the following negedge (ReqValid dropped there).
    task automatic issue(input logic [3:0] fs, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] rep);
        @(negedge CLK);
        bus.ReqValid  = 1'b1;
        bus.ReqFunSel = fs;
        bus.ReqA      = a;
        bus.ReqB      = b;
        bus.ReqRepeat = rep;
        chk("req_ready_before_accept", {31'd0, bus.ReqReady}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.ReqValid = 1'b0;
        chk("busy_after_accept", {31'd0, bus.Busy}, 32'd1);
    endtask

    // Counts edges after the accept edge until RspValid is seen.
    task automatic wait_rsp(output int n);
        n = 0;
        while (1) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (bus.RspValid === 1'b1) break;
            if (n > 200) begin
                failures++;
                $display("FAIL rsp_timeout: actual=no_rsp required=RspValid");
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] fs;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] rep;
        logic [7:0] exp_data;
        logic [3:0] exp_zcno;
        int         exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #300000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;

        vecs[0] = '{4'h4, 8'h05, 8'h02, 4'd0,  8'h07, 4'b0000, 2};
        vecs[1] = '{4'h4, 8'h7F, 8'h01, 4'd0,  8'h80, 4'b0011, 2};
        vecs[2] = '{4'hF, 8'h40, 8'h00, 4'd9,  8'h01, 4'b0100, 20};
        vecs[3] = '{4'h4, 8'hFF, 8'h01, 4'd0,  8'h00, 4'b1100, 2};
        vecs[4] = '{4'h4, 8'h01, 8'h01, 4'd3,  8'h05, 4'b0000, 8};
        vecs[5] = '{4'h0, 8'h00, 8'h33, 4'd0,  8'h00, 4'b1000, 2};
        vecs[6] = '{4'hF, 8'h01, 8'h00, 4'd15, 8'h01, 4'b0100, 32};

        bus.ReqValid  = 1'b0;
        bus.ReqFunSel = 4'h0;
        bus.ReqA      = 8'h00;
        bus.ReqB      = 8'h00;
        bus.ReqRepeat = 4'd0;
        bus.RspReady  = 1'b1;
        Reset         = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", {31'd0, bus.ReqReady}, 32'd1);
        chk("rst_busy",      {31'd0, bus.Busy},     32'd0);
        chk("rst_rsp_valid", {31'd0, bus.RspValid}, 32'd0);
        chk("rst_a",         {24'd0, bus.A},        32'h00);
        chk("rst_b",         {24'd0, bus.B},        32'h00);
        chk("rst_funsel",    {28'd0, bus.FunSel},   32'h0);
        chk("rst_rsp_data",  {24'd0, bus.RspData},  32'h00);
        chk("rst_rsp_zcno",  {28'd0, bus.RspZCNO},  32'h0);
        Reset = 1'b1;

        // Table-driven operations with RspReady held high.
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].rep);
            wait_rsp(n);
            chk($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
            chk($sformatf("v%0d_rsp_data", i), {24'd0, bus.RspData}, {24'd0, vecs[i].exp_data});
            chk($sformatf("v%0d_rsp_zcno", i), {28'd0, bus.RspZCNO}, {28'd0, vecs[i].exp_zcno});
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("v%0d_rsp_dropped", i), {31'd0, bus.RspValid}, 32'd0);
            chk($sformatf("v%0d_idle_ready", i), {31'd0, bus.ReqReady}, 32'd1);
        end

        // A sequence on the alu port during a chained rotate.
        issue(4'hF, 8'h40, 8'h00, 4'd9);
        chk("trace_a0", {24'd0, bus.A}, 32'h40);
        for (int e = 1; e <= 6; e++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (e == 2) chk("trace_a1", {24'd0, bus.A}, 32'h80);
            if (e == 4) chk("trace_a2", {24'd0, bus.A}, 32'h01);
            if (e == 6) chk("trace_a3", {24'd0, bus.A}, 32'h02);
        end
        n = 0;
        while (bus.RspValid !== 1'b1 && n < 100) begin
            @(posedge CLK);
            @(negedge CLK);
            n++;
        end
        chk("trace_rsp_data", {24'd0, bus.RspData}, 32'h01);
        @(posedge CLK);
        @(negedge CLK);

        // Backpressure in RESP with an ignored request pulse.
        bus.RspReady = 1'b0;
        issue(4'h4, 8'h05, 8'h02, 4'd0);
        wait_rsp(n);
        chk("bp_latency", n, 2);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.ReqValid  = 1'b1;
                bus.ReqA      = 8'hAA;
                bus.ReqFunSel = 4'h0;
                chk("bp_req_ready_low", {31'd0, bus.ReqReady}, 32'd0);
            end
            @(posedge CLK);
            @(negedge CLK);
            bus.ReqValid = 1'b0;
            chk($sformatf("bp_valid_c%0d", c), {31'd0, bus.RspValid}, 32'd1);
            chk($sformatf("bp_data_c%0d", c), {24'd0, bus.RspData}, 32'h07);
            chk($sformatf("bp_zcno_c%0d", c), {28'd0, bus.RspZCNO}, 32'h0);
        end
        chk("bp_a_not_relatched", {24'd0, bus.A}, 32'h05);
        bus.RspReady = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("bp_release_valid", {31'd0, bus.RspValid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.ReqReady}, 32'd1);
        chk("bp_release_busy",  {31'd0, bus.Busy},     32'd0);

        // Reset during SAMPLE of a chained op; ReqValid high during reset.
        issue(4'h4, 8'h01, 8'h01, 4'd3);
        @(posedge CLK);
        @(negedge CLK);
        Reset         = 1'b0;
        bus.ReqValid  = 1'b1;
        bus.ReqA      = 8'h77;
        bus.ReqB      = 8'h66;
        bus.ReqFunSel = 4'h4;
        @(posedge CLK);
        @(negedge CLK);
        Reset        = 1'b1;
        bus.ReqValid = 1'b0;
        chk("mid_rst_busy",      {31'd0, bus.Busy},     32'd0);
        chk("mid_rst_rsp_valid", {31'd0, bus.RspValid}, 32'd0);
        chk("mid_rst_ready",     {31'd0, bus.ReqReady}, 32'd1);
        chk("mid_rst_a",         {24'd0, bus.A},        32'h00);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (bus.RspValid === 1'b1) n++;
        end
        chk("mid_rst_no_rsp", n, 0);
        issue(4'h4, 8'h05, 8'h02, 4'd0);
        wait_rsp(n);
        chk("post_rst_latency", n, 2);
        chk("post_rst_data", {24'd0, bus.RspData}, 32'h07);
        chk("post_rst_zcno", {28'd0, bus.RspZCNO}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        chk("post_rst_idle", {31'd0, bus.ReqReady}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
